// File: rtl/ring_fifo_pkg.sv
// Shared sizing helpers and configuration checks for ring_fifo.
package ring_fifo_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit cfg_ok(input int unsigned depth, input int unsigned afull_th,
                                input int unsigned aempty_th);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull_th <= depth) && (aempty_th < depth);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, two asynchronous read ports.
module fifo_regfile
  import ring_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]          rdata_o,
  input  logic [ptr_w(DEPTH)-1:0]   paddr_i,
  output logic [WIDTH-1:0]          pdata_o
);

  // Contents are never reset; readers gate stale entries themselves.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign pdata_o = mem_q[paddr_i];

endmodule

// File: rtl/ring_fifo.sv
// Parametrised circular FIFO with occupancy count, threshold flags, sticky errors,
// synchronous flush and a combinational peek port.
module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_TH  = DEPTH - 1,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    en_in,
  input  logic [WIDTH-1:0]        in,
  input  logic                    en_out,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic [ptr_w(DEPTH)-1:0] peek_addr,
  output logic [WIDTH-1:0]        peek_data,
  output logic                    peek_valid
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] AfullC  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_TH);

  if (!cfg_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("ring_fifo: DEPTH must be a power of two >= 2, AFULL_TH <= DEPTH, AEMPTY_TH < DEPTH");
  end

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             deq_ok, enq_ok, wr_en;
  logic [WIDTH-1:0] rd_data, pk_data;
  logic [PW-1:0]    pk_addr;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthC);
  assign almost_full  = (count_q >= AfullC);
  assign almost_empty = (count_q <= AemptyC);

  // Acceptance depends only on registered occupancy; a full FIFO still accepts when draining.
  assign deq_ok = en_out & ~empty;
  assign enq_ok = en_in & (~full | deq_ok);
  assign wr_en  = enq_ok & ~flush;

  assign pk_addr    = head_q + peek_addr;
  assign peek_valid = ({1'b0, peek_addr} < count_q);
  assign peek_data  = peek_valid ? pk_data : '0;

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk_i   (CLK100MHZ),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i (in),
    .raddr_i (head_q),
    .rdata_o (rd_data),
    .paddr_i (pk_addr),
    .pdata_o (pk_data)
  );

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (enq_ok) begin
        tail_d = tail_q + PW'(1);
      end
      if (deq_ok) begin
        head_d      = head_q + PW'(1);
        out_d       = rd_data;
        out_valid_d = 1'b1;
      end
      unique case ({enq_ok, deq_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (en_in & ~enq_ok);
      underflow_d = underflow_q | (en_out & ~deq_ok);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo with a queue model and an output scoreboard.
module tb_ring_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_in, en_out, flush;
  logic [3:0] in;
  logic [3:0] out;
  logic       out_valid, empty, full, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;
  logic [2:0] peek_addr;
  logic [3:0] peek_data;
  logic       peek_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] model[$];
  logic [3:0] exp_q[$];
  logic [3:0] last_out;
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  ring_fifo #(
    .WIDTH     (4),
    .DEPTH     (8),
    .AFULL_TH  (7),
    .AEMPTY_TH (1)
  ) dut (
    .CLK100MHZ    (clk),
    .reset        (reset),
    .en_in        (en_in),
    .in           (in),
    .en_out       (en_out),
    .flush        (flush),
    .out          (out),
    .out_valid    (out_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .peek_addr    (peek_addr),
    .peek_data    (peek_data),
    .peek_valid   (peek_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int sz;
    sz = model.size();
    check({tag, " count"}, 32'(count), 32'(sz));
    check({tag, " empty"}, 32'(empty), 32'(sz == 0));
    check({tag, " full"}, 32'(full), 32'(sz == 8));
    check({tag, " almost_full"}, 32'(almost_full), 32'(sz >= 7));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(sz <= 1));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
    check({tag, " out_hold"}, 32'(out), 32'(last_out));
  endtask

  task automatic cycle(input string tag, input logic ei, input logic [3:0] d,
                       input logic eo, input logic fl);
    bit deq, enq;
    deq = eo && (model.size() != 0);
    enq = ei && ((model.size() < 8) || deq);
    if (fl) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (deq) begin
        exp_q.push_back(model[0]);
        last_out = model[0];
        void'(model.pop_front());
      end
      if (enq) model.push_back(d);
      if (ei && !enq) m_ovf = 1'b1;
      if (eo && !deq) m_unf = 1'b1;
    end
    en_in  = ei;
    in     = d;
    en_out = eo;
    flush  = fl;
    @(posedge clk);
    #1;
    en_in  = 1'b0;
    en_out = 1'b0;
    flush  = 1'b0;
    check({tag, " out_valid"}, 32'(out_valid), 32'(deq && !fl));
    if (out_valid) begin
      check({tag, " sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check({tag, " out_data"}, 32'(out), 32'(exp_q.pop_front()));
    end
    check_status(tag);
  endtask

  task automatic peek_all(input string tag);
    logic [3:0] exp_d;
    bit         exp_v;
    for (int i = 0; i < 8; i++) begin
      peek_addr = 3'(i);
      #1;
      exp_v = (i < model.size());
      exp_d = exp_v ? model[i] : 4'h0;
      check({tag, " peek_valid"}, 32'(peek_valid), 32'(exp_v));
      check({tag, " peek_data"}, 32'(peek_data), 32'(exp_d));
    end
    peek_addr = 3'd0;
  endtask

  task automatic clear_model();
    model.delete();
    exp_q.delete();
    last_out = 4'h0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    en_in     = 1'b0;
    en_out    = 1'b0;
    flush     = 1'b0;
    in        = 4'h0;
    peek_addr = 3'd0;
    clear_model();
    #2;
    check_status("reset");
    check("reset out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: fill, then overflow on a 9th enqueue
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 4'(i), 1'b0, 1'b0);
    cycle("ovf", 1'b1, 4'h9, 1'b0, 1'b0);
    check("ovf set", 32'(overflow), 32'd1);
    peek_all("full peek");

    // 2: drain, then underflow on a 9th dequeue
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 4'h0, 1'b1, 1'b0);
    cycle("unf", 1'b0, 4'h0, 1'b1, 1'b0);
    check("unf out stays 8", 32'(out), 32'd8);

    // 3: simultaneous requests when empty, then when full
    cycle("flush0", 1'b0, 4'h0, 1'b0, 1'b1);
    cycle("both_empty", 1'b1, 4'h5, 1'b1, 1'b0);
    check("both_empty unf", 32'(underflow), 32'd1);
    for (int i = 0; i < 7; i++) cycle("refill", 1'b1, 4'(4'hA + i), 1'b0, 1'b0);
    cycle("both_full", 1'b1, 4'h3, 1'b1, 1'b0);
    check("both_full out oldest", 32'(out), 32'd5);
    peek_all("both_full peek");

    // 4: mixed traffic across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle("mix", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b0);
      peek_all("mix peek");
    end

    // 5: flush beats a same-cycle enqueue
    cycle("flush1", 1'b0, 4'h0, 1'b0, 1'b1);
    cycle("pre_unf", 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("three", 1'b1, 4'(i + 2), 1'b0, 1'b0);
    cycle("flush_enq", 1'b1, 4'hF, 1'b0, 1'b1);
    check("flush_enq count", 32'(count), 32'd0);
    peek_all("flush_enq peek");

    // 6: asynchronous reset mid-burst
    cycle("pre_rst_unf", 1'b0, 4'h0, 1'b1, 1'b0);
    cycle("burst", 1'b1, 4'h7, 1'b0, 1'b0);
    cycle("burst", 1'b1, 4'h6, 1'b1, 1'b0);
    en_in = 1'b1;
    in    = 4'h4;
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    check_status("async_rst");
    check("async_rst out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst_cycle enq dropped", 32'(count), 32'd0);
    en_in = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle("resume", 1'b1, 4'(4'hC + i), 1'b0, 1'b0);
    peek_all("resume peek");
    for (int i = 0; i < 3; i++) cycle("resume_drain", 1'b0, 4'h0, 1'b1, 1'b0);
    check("sb drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_fifo.md
# ring_fifo

Parametrised circular FIFO that succeeds the fixed 8×4 display queue. It is generalised in data width and depth, and adds several behaviours the earlier queue lacked: same-cycle enqueue and dequeue, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow errors, synchronous flush, and a combinational peek port. The peek port lets the 7-segment scan logic display any live entry without disturbing the queue. The block sits between the board switch/button front end (already debounced and pulsed) and the display multiplexer, all in one clock domain.

## Interface
Parameters:
- WIDTH, 4: data width in bits.
- DEPTH, 8: number of entries; must be a power of two, ≥ 2.
- AFULL_TH, DEPTH-1: almost_full asserts when count ≥ AFULL_TH.
- AEMPTY_TH, 1: almost_empty asserts when count ≤ AEMPTY_TH.

Ports:
- CLK100MHZ, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- en_in, input, 1: enqueue request, one entry per cycle while high.
- in, input, WIDTH: enqueue data.
- en_out, input, 1: dequeue request.
- flush, input, 1: synchronous clear of contents.
- out, output, WIDTH: last dequeued data, registered.
- out_valid, output, 1: one-cycle pulse, out updated this cycle.
- empty, output, 1: count == 0.
- full, output, 1: count == DEPTH.
- almost_full, output, 1: count ≥ AFULL_TH.
- almost_empty, output, 1: count ≤ AEMPTY_TH.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; set by a rejected enqueue.
- underflow, output, 1: sticky; set by a rejected dequeue.
- peek_addr, input, $clog2(DEPTH): offset from head (0 = oldest entry).
- peek_data, output, WIDTH: entry at head+peek_addr; 0 when not valid.
- peek_valid, output, 1: peek_addr < count.

## Operation
- State: head and tail pointers of $clog2(DEPTH) bits, both wrapping modulo DEPTH; count register; DEPTH×WIDTH storage.
- Acceptance is computed from registered state only:
  - deq_ok = en_out & ~empty.
  - enq_ok = en_in & (~full | deq_ok).
- enq_ok: mem[tail] ← in; tail ← tail+1.
- deq_ok: out ← mem[head]; head ← head+1; out_valid ← 1.
- Count update:
  - count + 1 when only enq_ok.
  - count − 1 when only deq_ok.
  - unchanged when both or neither.
- Empty with en_in & en_out: only the enqueue happens. There is no bypass, out is unchanged and underflow is set.
- Full with en_in & en_out: both happen and count stays DEPTH.
- Rejected requests:
  - en_in & ~enq_ok sets overflow.
  - en_out & ~deq_ok sets underflow.
  - Both flags hold until reset or flush.
- flush has priority over en_in/en_out in the same cycle:
  - head, tail and count go to 0; overflow and underflow clear.
  - out holds its value; out_valid is 0.
- Flags and peek outputs:
  - All status flags are decoded combinationally from the count register.
  - peek_data and peek_valid are combinational from peek_addr, head and count.
- Storage is not reset. Nothing can observe stale storage, because peek_data is forced to 0 when peek_valid is 0.

## Timing
- Reset (asynchronous, immediate) sets:
  - head = tail = count = 0.
  - out = 0, out_valid = 0.
  - overflow = underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_TH == 0).
- Reset has effect mid-operation: an enqueue or dequeue in the reset cycle is discarded.
- Enqueue to visibility on peek/empty: 1 cycle.
- Dequeue request to out/out_valid: 1 cycle (registered).
- Sustained throughput: one enqueue plus one dequeue per cycle.
- Pointer wrap from DEPTH-1 to 0 takes no extra cycle.

## Structure
- Package ring_fifo_pkg holds:
  - the pointer-width and count-width helper functions ($clog2-based);
  - the compile-time checks (DEPTH power of two, AFULL_TH ≤ DEPTH, AEMPTY_TH < DEPTH).
- One sub-module, fifo_regfile:
  - DEPTH×WIDTH array;
  - one synchronous write port;
  - two asynchronous read ports, one for dequeue and one for peek.
- Pointer, count and flag logic live in ring_fifo.

## Test plan
Parameters: WIDTH=4, DEPTH=8, AFULL_TH=7, AEMPTY_TH=1.
1. Reset, then enqueue 1..8 on consecutive cycles.
   - Expect count=8, full=1, almost_full from the 7th entry.
   - A 9th en_in sets overflow and leaves peek offset 7 = 8.
2. Dequeue 8 times.
   - Expect out = 1..8, each with an out_valid pulse 1 cycle after request.
   - A 9th en_out sets underflow; out stays 8.
3. Simultaneous en_in/en_out:
   - When empty with in=5: count=1, out unchanged, underflow=1.
   - When full: count stays 8, out = oldest entry, new data lands at the tail.
4. Wrap: run 20 mixed cycles so the pointers cross index 7→0.
   - Peek offsets 0..count-1 match a scoreboard model.
   - peek_data = 0 for offsets ≥ count.
5. flush asserted together with en_in while count=3:
   - Next cycle count=0, empty=1, error flags clear, the enqueue is dropped.
6. Assert reset asynchronously mid-burst (between clock edges):
   - All outputs reach their reset values before the next edge.
   - The FIFO resumes correctly after release.
